d_branch_unit: RTL and testbench

- Decode-stage branch resolution unit for the 5-stage MIPS pipeline.
- Evaluates the branch condition on forwarded rs/rt operands and produces the taken (jump) and delay-slot annul (flush) decisions.
- Holds a PC-indexed table of saturating counters that gives a taken/not-taken prediction and reports mispredicts.
- Sits between the D-stage register-file/forwarding muxes and the NPC/hazard logic.

---
 rtl/d_branch_unit.sv | 154 +++++++++++++++
 tb/tb_d_branch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/d_branch_unit.sv
// ---------------------------------------------------------------------------
// d_branch_unit
//
// Decode-stage branch resolution unit for the 5-stage MIPS pipeline.
//
// The branch condition is evaluated on the forwarded rs/rt operands. From it
// the unit derives three decisions:
//   - jump : the branch is taken
//   - flush: the delay slot is annulled
//   - link : PC+8 is written to $31
//
// A PC-indexed table of saturating counters supplies a taken/not-taken
// prediction, and the unit flags a mispredict whenever that prediction
// disagrees with the resolved outcome.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-low reset
//   stall      in   D stage stalled; blocks table and statistics updates
//   valid      in   D stage holds a real instruction
//   cmp_op     in   0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez,
//                   7 bltzal
//   pc         in   PC of the D-stage instruction
//   rs_data    in   forwarded rs operand
//   rt_data    in   forwarded rt operand
//   jump       out  branch condition true
//   flush      out  annul the delay slot (untaken bltzal)
//   link       out  write PC+8 to $31 (any active bltzal)
//   pred_taken out  predictor MSB for the indexed entry
//   mispredict out  prediction disagrees with resolution
//   br_total   out  resolved branch count
//   br_miss    out  mispredict count
//
// Optional feature, macro D_BRANCH_UNIT_STAT_EN:
//   When the macro is defined, br_total and br_miss are saturating counters.
//   When it is undefined, both outputs are tied to 0.
// ---------------------------------------------------------------------------
module d_branch_unit #(
  parameter int WIDTH     = 32,
  parameter int BHT_DEPTH = 16,
  parameter int CNT_BITS  = 2,
  parameter int STAT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 valid,
  input  logic [2:0]           cmp_op,
  input  logic [WIDTH-1:0]     pc,
  input  logic [WIDTH-1:0]     rs_data,
  input  logic [WIDTH-1:0]     rt_data,
  output logic                 jump,
  output logic                 flush,
  output logic                 link,
  output logic                 pred_taken,
  output logic                 mispredict,
  output logic [STAT_BITS-1:0] br_total,
  output logic [STAT_BITS-1:0] br_miss
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  // Weakly-not-taken: MSB clear, all lower bits set (0 when CNT_BITS == 1).
  localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

  logic                act;
  logic                cond;
  logic                rs_neg;
  logic                rs_zero;
  logic                upd;
  logic [IDX_W-1:0]    idx;
  logic [CNT_BITS-1:0] cnt_cur;
  logic [CNT_BITS-1:0] cnt_d;
  logic [CNT_BITS-1:0] cnt_q [BHT_DEPTH];

  // The word-offset bits and the PC bits above the index take no part in
  // the lookup.
  logic unused_pc;
  assign unused_pc = ^{pc[WIDTH-1:IDX_W+2], pc[1:0]};

  assign act     = valid && (cmp_op != 3'd0);
  assign rs_neg  = rs_data[WIDTH-1];
  assign rs_zero = (rs_data == '0);

  // The sign bit and the zero test together cover every signed compare
  // against zero.
  always_comb begin
    cond = 1'b0;
    case (cmp_op)
      3'd1:    cond = (rs_data == rt_data);
      3'd2:    cond = (rs_data != rt_data);
      3'd3:    cond = rs_neg || rs_zero;
      3'd4:    cond = !rs_neg && !rs_zero;
      3'd5:    cond = rs_neg;
      3'd6:    cond = !rs_neg;
      3'd7:    cond = rs_neg;
      default: cond = 1'b0;
    endcase
  end

  assign jump  = act && cond;
  assign link  = act && (cmp_op == 3'd7);
  assign flush = link && !jump;

  // The lookup reads the registered table state, so a branch always sees
  // the pre-update value of its own entry.
  assign idx        = pc[IDX_W+1:2];
  assign cnt_cur    = cnt_q[idx];
  assign pred_taken = act && cnt_cur[CNT_BITS-1];
  assign mispredict = act && (pred_taken != jump);

  assign upd = act && !stall;

  // Saturating increment when taken, saturating decrement when not taken.
  always_comb begin
    cnt_d = cnt_cur;
    if (jump) begin
      if (cnt_cur != CNT_MAX) cnt_d = cnt_cur + CNT_BITS'(1);
    end else begin
      if (cnt_cur != '0) cnt_d = cnt_cur - CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) cnt_q[i] <= CNT_INIT;
    end else if (upd) begin
      cnt_q[idx] <= cnt_d;
    end
  end

`ifdef D_BRANCH_UNIT_STAT_EN
  logic [STAT_BITS-1:0] total_q;
  logic [STAT_BITS-1:0] miss_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      total_q <= '0;
      miss_q  <= '0;
    end else if (upd) begin
      if (total_q != '1) total_q <= total_q + STAT_BITS'(1);
      if (mispredict && (miss_q != '1)) miss_q <= miss_q + STAT_BITS'(1);
    end
  end

  assign br_total = total_q;
  assign br_miss  = miss_q;
`else
  assign br_total = '0;
  assign br_miss  = '0;
`endif

endmodule

// File: tb/tb_d_branch_unit.sv
module tb_d_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        valid;
  logic [2:0]  cmp_op;
  logic [31:0] pc;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        jump;
  logic        flush;
  logic        link;
  logic        pred_taken;
  logic        mispredict;
  logic [15:0] br_total;
  logic [15:0] br_miss;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  d_branch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .valid      (valid),
    .cmp_op     (cmp_op),
    .pc         (pc),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .jump       (jump),
    .flush      (flush),
    .link       (link),
    .pred_taken (pred_taken),
    .mispredict (mispredict),
    .br_total   (br_total),
    .br_miss    (br_miss)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Check all five combinational decision outputs at once.
  task automatic chk_out(input string tag, input logic j, input logic f, input logic l,
                         input logic p, input logic m);
    chk({tag, ".jump"}, 32'(jump), 32'(j));
    chk({tag, ".flush"}, 32'(flush), 32'(f));
    chk({tag, ".link"}, 32'(link), 32'(l));
    chk({tag, ".pred"}, 32'(pred_taken), 32'(p));
    chk({tag, ".mispredict"}, 32'(mispredict), 32'(m));
    $display("txn %s: jump=%0b flush=%0b link=%0b pred=%0b mis=%0b",
             tag, jump, flush, link, pred_taken, mispredict);
  endtask

  // Statistics exist only in the STAT_EN build; otherwise they read 0.
  task automatic chk_stats(input string tag, input int t, input int m);
`ifdef D_BRANCH_UNIT_STAT_EN
    chk({tag, ".br_total"}, 32'(br_total), 32'(t));
    chk({tag, ".br_miss"}, 32'(br_miss), 32'(m));
`else
    chk({tag, ".br_total"}, 32'(br_total), 32'(t * 0));
    chk({tag, ".br_miss"}, 32'(br_miss), 32'(m * 0));
`endif
  endtask

  // Inputs change 1 time unit after a rising edge and settle before checks.
  task automatic drive(input logic v, input logic s, input logic [2:0] op,
                       input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
    valid   = v;
    stall   = s;
    cmp_op  = op;
    pc      = p;
    rs_data = a;
    rt_data = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bvals [4];
  logic [3:0]  bexp  [4];

  initial begin
    // Signed-boundary operands and expected outcomes for blez/bgtz/bltz/bgez.
    // Bit i of each bexp entry is the outcome for bvals[i].
    bvals = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0001, 32'h7FFF_FFFF};
    bexp  = '{4'b0011, 4'b1100, 4'b0001, 4'b1110};

    // Reset with the D stage empty.
    reset = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    chk_out("reset_idle", 0, 0, 0, 0, 0);
    chk_stats("reset", 0, 0);
    reset = 1'b1;

    // valid=0 masks a condition that would be true.
    drive(1'b0, 1'b0, 3'd1, 32'h3000, 32'd5, 32'd5);
    chk_out("invalid_beq", 0, 0, 0, 0, 0);
    tick();

    // First taken beq at pc 0x3000 (entry 0, reset value 01).
    drive(1'b1, 1'b0, 3'd1, 32'h3000, 32'd5, 32'd5);
    chk_out("beq_first", 1, 0, 0, 0, 1);
    tick();
    chk_stats("beq_first", 1, 1);

    // Entry 0 is now 10. Peek it under stall with a not-taken beq.
    drive(1'b1, 1'b1, 3'd1, 32'h3000, 32'd5, 32'd6);
    chk_out("beq_peek", 0, 0, 0, 1, 1);
    tick();
    chk_stats("beq_peek_stall", 1, 1);

    // Taken bltzal at pc 0x3008 (entry 2).
    drive(1'b1, 1'b0, 3'd7, 32'h3008, 32'hFFFF_FFFF, 32'h0);
    chk_out("bltzal_taken", 1, 0, 1, 0, 1);
    tick();
    chk_stats("bltzal_taken", 2, 2);

    // Untaken bltzal: it links and flushes. Entry 2 moves from 10 back to 01.
    drive(1'b1, 1'b0, 3'd7, 32'h3008, 32'h0, 32'h0);
    chk_out("bltzal_nt", 0, 1, 1, 1, 1);
    tick();
    chk_stats("bltzal_nt", 3, 3);

    // Signed boundaries, stalled so that the table does not move.
    // Entry 12 is still 01, so mispredict follows jump.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, 1'b1, 3'(k + 3), 32'h3030, bvals[i], 32'h0);
        chk_out($sformatf("bnd_op%0d_v%0d", k + 3, i), bexp[k][i], 0, 0, 0, bexp[k][i]);
      end
    end

    // A bne with unequal operands is taken.
    drive(1'b1, 1'b1, 3'd2, 32'h3030, 32'd1, 32'd2);
    chk_out("bne_taken", 1, 0, 0, 0, 1);
    tick();
    chk_stats("after_bnd", 3, 3);

    // Saturation at pc 0x3010 (entry 4): five taken beqs drive it 01->10->11->11->11->11.
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 1'b0, 3'd1, 32'h3010, 32'd9, 32'd9);
      chk_out($sformatf("sat_taken%0d", n), 1, 0, 0, (n != 0), (n == 0));
      tick();
    end
    chk_stats("sat", 8, 4);

    // The first not-taken branch still predicts taken and mispredicts; entry becomes 10.
    drive(1'b1, 1'b0, 3'd1, 32'h3010, 32'd1, 32'd2);
    chk_out("sat_nt1", 0, 0, 0, 1, 1);
    tick();

    // At 10 the prediction stays taken; this update takes the entry to 01.
    drive(1'b1, 1'b0, 3'd1, 32'h3010, 32'd1, 32'd2);
    chk_out("sat_nt2", 0, 0, 0, 1, 1);
    tick();
    chk_stats("sat_nt", 10, 6);
    drive(1'b1, 1'b1, 3'd1, 32'h3010, 32'd1, 32'd1);
    chk_out("sat_peek", 1, 0, 0, 0, 1);

    // Hold a taken branch at pc 0x3020 (entry 8) stalled for 3 cycles.
    for (int n = 0; n < 3; n++) begin
      drive(1'b1, 1'b1, 3'd1, 32'h3020, 32'd3, 32'd3);
      chk_out($sformatf("stall%0d", n), 1, 0, 0, 0, 1);
      tick();
    end
    chk_stats("stall_held", 10, 6);

    // Release the stall: the branch updates exactly once (entry 8 goes 01 -> 10).
    drive(1'b1, 1'b0, 3'd1, 32'h3020, 32'd3, 32'd3);
    chk_out("stall_release", 1, 0, 0, 0, 1);
    tick();
    chk_stats("stall_release", 11, 7);

    // Entry 8 should now read 10, not 11: one not-taken update brings it to 01.
    drive(1'b1, 1'b0, 3'd1, 32'h3020, 32'd3, 32'd4);
    chk_out("stall_nt", 0, 0, 0, 1, 1);
    tick();
    drive(1'b1, 1'b1, 3'd1, 32'h3020, 32'd3, 32'd4);
    chk_out("stall_peek", 0, 0, 0, 0, 0);
    chk_stats("stall_nt", 12, 8);

    // Aliasing: pc 0x3004 and pc 0x3044 both map to entry 1.
    drive(1'b1, 1'b0, 3'd1, 32'h3004, 32'd7, 32'd7);
    chk_out("alias_a", 1, 0, 0, 0, 1);
    tick();
    drive(1'b1, 1'b0, 3'd1, 32'h3044, 32'd7, 32'd7);
    chk_out("alias_b", 1, 0, 0, 1, 0);
    tick();
    chk_stats("alias", 14, 9);

    // Mid-run reset. Outputs still follow the inputs (entry 1 is 11 until the edge).
    reset = 1'b0;
    drive(1'b1, 1'b0, 3'd1, 32'h3004, 32'd7, 32'd7);
    chk_out("reset_mid", 1, 0, 0, 1, 0);
    tick();
    reset = 1'b1;
    chk_stats("reset_mid", 0, 0);

    // After the reset, entries 1 and 0 read weakly-not-taken.
    drive(1'b1, 1'b1, 3'd1, 32'h3044, 32'd7, 32'd7);
    chk_out("reset_peek1", 1, 0, 0, 0, 1);
    drive(1'b1, 1'b1, 3'd1, 32'h3000, 32'd7, 32'd7);
    chk_out("reset_peek0", 1, 0, 0, 0, 1);

    // One taken update from 01 gives 10, which confirms the reset value was 01.
    drive(1'b1, 1'b0, 3'd1, 32'h3044, 32'd7, 32'd7);
    chk_out("post_reset_upd", 1, 0, 0, 0, 1);
    tick();
    chk_stats("post_reset_upd", 1, 1);
    drive(1'b1, 1'b1, 3'd1, 32'h3004, 32'd7, 32'd8);
    chk_out("post_reset_peek", 0, 0, 0, 1, 1);

    // cmp_op 0, and valid=0 on a taken bltzal: every decision output is 0.
    drive(1'b1, 1'b0, 3'd0, 32'h3004, 32'd7, 32'd7);
    chk_out("op_none", 0, 0, 0, 0, 0);
    drive(1'b0, 1'b0, 3'd7, 32'h3004, 32'hFFFF_FFFF, 32'd0);
    chk_out("invalid_bltzal", 0, 0, 0, 0, 0);
    tick();
    chk_stats("no_update", 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
